msrv32_pc_unit: RTL

MSRV32_PC_UNIT -- requirements
Module: msrv32_pc_unit

---
 rtl/msrv32_pc_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/msrv32_pc_unit.sv
// msrv32_pc_unit
// Program counter unit: selects the next PC, keeps the registered PC and
// drives the instruction fetch address. A small BOOT/RUN/STALL machine
// keeps the fetch address stable while instruction memory is not ready.

module msrv32_pc_unit #(
   parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [1:0]  pc_src_in,
   input  logic        branch_taken_in,
   input  logic [31:0] iadder_in,
   input  logic [31:0] epc_in,
   input  logic [31:0] trap_address_in,
   input  logic        ahb_ready_in,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus_4_out,
   output logic [31:0] pc_mux_out,
   output logic [31:0] iaddr_out,
   output logic        misaligned_instr_out
);

   localparam logic [1:0] BOOT  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] STALL = 2'd2;

   localparam logic [1:0] SRC_BOOT = 2'b00;
   localparam logic [1:0] SRC_EPC  = 2'b01;
   localparam logic [1:0] SRC_TRAP = 2'b10;

   logic [1:0]  state;
   logic [31:0] held_addr;
   logic [31:0] branch_target;
   logic [31:0] next_pc;
   logic [31:0] fetch_addr;

   // JALR semantics: bit 0 of the computed target is always dropped
   assign branch_target = iadder_in & 32'hFFFF_FFFE;
   assign pc_plus_4_out = pc_out + 32'd4;
   assign next_pc       = branch_taken_in ? branch_target : pc_plus_4_out;

   // Only a taken branch/jump can produce a target that is not word aligned
   assign misaligned_instr_out = (pc_src_in == 2'b11) && branch_taken_in && branch_target[1];

   // Next-PC source selection
   always_comb begin
      case (pc_src_in)
         SRC_BOOT: pc_mux_out = BOOT_ADDRESS;
         SRC_EPC:  pc_mux_out = epc_in;
         SRC_TRAP: pc_mux_out = trap_address_in;
         default:  pc_mux_out = next_pc;
      endcase
   end

   // Fetch address depends on the state; the low two bits are always cleared
   always_comb begin
      case (state)
         BOOT:    fetch_addr = BOOT_ADDRESS;
         STALL:   fetch_addr = held_addr;
         default: fetch_addr = pc_mux_out;
      endcase
      iaddr_out = fetch_addr & 32'hFFFF_FFFC;
   end

   // State, PC and held-address registers; the held address keeps the full
   // next-PC value so a misaligned target is still loaded into pc_out later
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state     <= BOOT;
         pc_out    <= BOOT_ADDRESS;
         held_addr <= BOOT_ADDRESS;
      end else begin
         case (state)
            BOOT: begin
               if (ahb_ready_in) begin
                  state  <= RUN;
                  pc_out <= BOOT_ADDRESS;
               end
            end
            RUN: begin
               if (ahb_ready_in) begin
                  pc_out <= pc_mux_out;
               end else begin
                  state     <= STALL;
                  held_addr <= pc_mux_out;
               end
            end
            STALL: begin
               if (ahb_ready_in) begin
                  state  <= RUN;
                  pc_out <= held_addr;
               end
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule
